seq_alu: RTL

Parametrised, multi-cycle successor to the datapath ALU. Executes the same 4-bit opcode set (add, subtract, multiply, divide, AND, OR, XOR, shift left/right, increment, decrement) on WIDTH-bit signed operands, with an iterative shift-add multiplier and restoring divider in place of combinational ones. Sits between the instruction-decode stage and the writeback/cache path, with valid/ready handshakes on both sides so either side can stall it.

---
 rtl/seq_alu.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Multi-cycle signed ALU with valid/ready handshakes: single-cycle logic/add ops,
// shift-add multiplier and (when SEQ_ALU_DIV_EN is defined) a restoring divider.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_DEC = 4'hA;

  localparam logic [WIDTH:0]   ONE_X  = 1;
  localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(WIDTH);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH:0]     wk_q;
  logic [WIDTH-1:0]     mag_b_q;
  logic                 neg_res_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 carry_q;
  logic                 err_q;

  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_carry;
  logic                 sc_err;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       mul_hi;
  logic [2*WIDTH:0]     mul_d;
  logic [2*WIDTH-1:0]   fix_d;

`ifdef SEQ_ALU_DIV_EN
  logic                 neg_rem_q;
  logic                 is_div_q;
  logic [WIDTH:0]       div_rs;
  logic                 div_ge;
  logic [WIDTH:0]       div_rem;
  logic [2*WIDTH:0]     div_d;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign err       = err_q;

  assign a_mag = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign b_mag = operand_b[WIDTH-1] ? -operand_b : operand_b;

  always_comb begin
    sum      = '0;
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_err   = 1'b0;
    case (opcode)
      OP_ADD: begin
        sum      = {1'b0, operand_a} + {1'b0, operand_b};
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
      end
      OP_SUB: begin
        sum      = {1'b0, operand_a} + {1'b0, ~operand_b} + ONE_X;
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
      end
      OP_INC: begin
        sum      = {1'b0, operand_a} + ONE_X;
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
      end
      OP_DEC: begin
        sum      = {1'b0, operand_a} + {1'b0, {WIDTH{1'b1}}};
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
      end
      OP_AND:  sc_res = operand_a & operand_b;
      OP_OR:   sc_res = operand_a | operand_b;
      OP_XOR:  sc_res = operand_a ^ operand_b;
      OP_SHL:  sc_res = (operand_b >= SH_LIM) ? '0 : (operand_a << operand_b);
      OP_SHR:  sc_res = (operand_b >= SH_LIM) ? '0 : (operand_a >> operand_b);
      OP_MUL:  ;
`ifdef SEQ_ALU_DIV_EN
      OP_DIV:  ;
`endif
      default: sc_err = 1'b1;
    endcase
  end

  // Multiplier: low half holds the remaining multiplier bits, high half the partial sum.
  always_comb begin
    mul_hi = wk_q[2*WIDTH:WIDTH] + (wk_q[0] ? {1'b0, mag_b_q} : '0);
    mul_d  = {1'b0, mul_hi, wk_q[WIDTH-1:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  // Divider: high half is the partial remainder, low half shifts dividend out / quotient in.
  always_comb begin
    div_rs  = {wk_q[2*WIDTH-1:WIDTH], wk_q[WIDTH-1]};
    div_ge  = (div_rs >= {1'b0, mag_b_q});
    div_rem = div_ge ? (div_rs - {1'b0, mag_b_q}) : div_rs;
    div_d   = {div_rem, wk_q[WIDTH-2:0], div_ge};
  end
`endif

  always_comb begin
    fix_d = neg_res_q ? -wk_q[2*WIDTH-1:0] : wk_q[2*WIDTH-1:0];
`ifdef SEQ_ALU_DIV_EN
    quo = neg_res_q ? -wk_q[WIDTH-1:0] : wk_q[WIDTH-1:0];
    rem = neg_rem_q ? -wk_q[2*WIDTH-1:WIDTH] : wk_q[2*WIDTH-1:WIDTH];
    if (is_div_q) fix_d = {rem, quo};
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wk_q      <= '0;
      mag_b_q   <= '0;
      neg_res_q <= 1'b0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            if (opcode == OP_MUL) begin
              wk_q      <= {{(WIDTH+1){1'b0}}, a_mag};
              mag_b_q   <= b_mag;
              neg_res_q <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
`ifdef SEQ_ALU_DIV_EN
              is_div_q  <= 1'b0;
`endif
              state_q   <= MUL;
`ifdef SEQ_ALU_DIV_EN
            end else if (opcode == OP_DIV) begin
              if (operand_b == '0) begin
                result_q <= '0;
                err_q    <= 1'b1;
                state_q  <= DONE;
              end else begin
                wk_q      <= {{(WIDTH+1){1'b0}}, a_mag};
                mag_b_q   <= b_mag;
                neg_res_q <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                neg_rem_q <= operand_a[WIDTH-1];
                is_div_q  <= 1'b1;
                state_q   <= DIV;
              end
`endif
            end else begin
              result_q <= {{WIDTH{sc_res[WIDTH-1]}}, sc_res};
              carry_q  <= sc_carry;
              err_q    <= sc_err;
              state_q  <= DONE;
            end
          end
        end
        MUL: begin
          wk_q <= mul_d;
          if (cnt_q == CW'(WIDTH-1)) begin
            cnt_q   <= '0;
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`ifdef SEQ_ALU_DIV_EN
        DIV: begin
          wk_q <= div_d;
          if (cnt_q == CW'(WIDTH-1)) begin
            cnt_q   <= '0;
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif
        FIX: begin
          result_q <= fix_d;
          state_q  <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
